// File: rtl/pmp_cfg_regs.sv
// PMP configuration CSR bank: pmpcfg/pmpaddr storage with WARL and lock rules,
// served over a valid/ready request port with a one-cycle response.
module pmp_cfg_regs #(
    parameter int XLEN       = 32,
    parameter int PMP_LEN    = 13,
    parameter int NR_ENTRIES = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_i,
    output logic                           ready_o,
    input  logic                           we_i,
    input  logic [11:0]                    addr_i,
    input  logic [XLEN-1:0]                wdata_i,
    output logic                           rvalid_o,
    output logic [XLEN-1:0]                rdata_o,
    output logic                           err_o,
    output logic [NR_ENTRIES*PMP_LEN-1:0]  conf_addr_o,
    output logic [NR_ENTRIES*8-1:0]        conf_o
);
    localparam int EPC  = XLEN / 8;
    localparam int NCFG = (NR_ENTRIES + EPC - 1) / EPC;

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_RESP = 1'b1;

    logic               state_reg, state_next;
    logic [7:0]         cfg_reg   [NR_ENTRIES];
    logic [7:0]         cfg_next  [NR_ENTRIES];
    logic [PMP_LEN-1:0] paddr_reg [NR_ENTRIES];
    logic [PMP_LEN-1:0] paddr_next[NR_ENTRIES];
    logic [XLEN-1:0]    rdata_reg, rdata_next;
    logic               err_reg, err_next;

    logic       accept, wr_en, cfg_hit, paddr_hit;
    logic [3:0] csr_idx;

    assign csr_idx   = addr_i[3:0];
    assign accept    = req_i && (state_reg == STATE_IDLE);
    assign wr_en     = accept && we_i;
    assign cfg_hit   = (addr_i[11:4] == 8'h3A) && ({1'b0, csr_idx} < 5'(NCFG));
    assign paddr_hit = (addr_i[11:4] == 8'h3B) && ({1'b0, csr_idx} < 5'(NR_ENTRIES));

    // Lock checks use the pre-write register state, so a byte that sets L
    // in this write still takes its new value.
    generate
        for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_entry
            localparam int CSR_N  = gi / EPC;
            localparam int BYTE_K = gi % EPC;

            logic [7:0] wbyte;
            logic       locked, tor_guard, cfg_wr, paddr_wr;

            assign wbyte  = wdata_i[8*BYTE_K +: 8];
            assign locked = cfg_reg[gi][7];

            if (gi + 1 < NR_ENTRIES) begin : g_guard
                assign tor_guard = cfg_reg[gi+1][7] && (cfg_reg[gi+1][4:3] == 2'b01);
            end else begin : g_noguard
                assign tor_guard = 1'b0;
            end

            // W=1 with R=0 is an illegal combination: drop the whole byte.
            assign cfg_wr   = wr_en && cfg_hit && (csr_idx == 4'(CSR_N)) && !locked
                              && !(wbyte[1] && !wbyte[0]);
            assign paddr_wr = wr_en && paddr_hit && (csr_idx == 4'(gi)) && !locked && !tor_guard;

            assign cfg_next[gi]   = cfg_wr ? (wbyte & 8'h9F) : cfg_reg[gi];
            assign paddr_next[gi] = paddr_wr ? wdata_i[PMP_LEN-1:0] : paddr_reg[gi];

            assign conf_o[8*gi +: 8]                = cfg_reg[gi];
            assign conf_addr_o[PMP_LEN*gi +: PMP_LEN] = paddr_reg[gi];
        end
    endgenerate

    // Response data reflects the stored (post-WARL) value after any write.
    always_comb begin
        rdata_next = '0;
        err_next   = 1'b0;
        if (cfg_hit) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                if (i / EPC == int'(csr_idx)) begin
                    rdata_next[8*(i%EPC) +: 8] = cfg_next[i];
                end
            end
        end else if (paddr_hit) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                if (i == int'(csr_idx)) begin
                    rdata_next[PMP_LEN-1:0] = paddr_next[i];
                end
            end
        end else begin
            err_next = 1'b1;
        end
    end

    always_comb begin
        state_next = STATE_IDLE;
        if (state_reg == STATE_IDLE && accept) begin
            state_next = STATE_RESP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= STATE_IDLE;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                cfg_reg[i]   <= '0;
                paddr_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                cfg_reg[i]   <= cfg_next[i];
                paddr_reg[i] <= paddr_next[i];
            end
            if (accept) begin
                rdata_reg <= rdata_next;
                err_reg   <= err_next;
            end
        end
    end

    assign ready_o  = (state_reg == STATE_IDLE);
    assign rvalid_o = (state_reg == STATE_RESP) && !rst_i;
    assign rdata_o  = rdata_reg;
    assign err_o    = err_reg;

endmodule

// File: tb/tb_pmp_cfg_regs.sv
// Bench for pmp_cfg_regs: directed scenarios plus random CSR traffic checked
// against an array-based model of the PMP CSR rules.
module tb_pmp_cfg_regs;
    localparam int NR = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready, rvalid, err;
    logic [31:0] rdata;
    logic [NR*13-1:0] conf_addr;
    logic [NR*8-1:0]  conf;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  m_cfg  [NR];
    logic [12:0] m_addr [NR];

    pmp_cfg_regs #(.XLEN(32), .PMP_LEN(13), .NR_ENTRIES(NR)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .ready_o(ready), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
        .err_o(err), .conf_addr_o(conf_addr), .conf_o(conf)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_cfg[i]  = 8'h00;
            m_addr[i] = 13'h0;
        end
    endtask

    // Applies one CSR access to the model and returns the expected response.
    task automatic model_access(input logic w, input logic [11:0] a, input logic [31:0] d,
                                output logic [31:0] rd, output logic e);
        logic [7:0] pre [NR];
        int n;
        for (int i = 0; i < NR; i++) pre[i] = m_cfg[i];
        rd = '0;
        e  = 1'b0;
        if (a >= 12'h3A0 && a < 12'h3A0 + 12'((NR + 3) / 4)) begin
            n = int'(a - 12'h3A0);
            for (int k = 0; k < 4; k++) begin
                int idx;
                logic [7:0] b;
                idx = 4 * n + k;
                b = d[8*k +: 8];
                if (w && idx < NR && pre[idx][7] == 1'b0 && !(b[1] == 1'b1 && b[0] == 1'b0))
                    m_cfg[idx] = {b[7], 2'b00, b[4:0]};
                if (idx < NR) rd[8*k +: 8] = m_cfg[idx];
            end
        end else if (a >= 12'h3B0 && a < 12'h3B0 + 12'(NR)) begin
            n = int'(a - 12'h3B0);
            if (w && !pre[n][7] && !(n + 1 < NR && pre[n+1][7] && pre[n+1][4:3] == 2'b01))
                m_addr[n] = d[12:0];
            rd = {19'b0, m_addr[n]};
        end else begin
            e = 1'b1;
        end
    endtask

    function automatic logic [NR*8-1:0] model_conf();
        logic [NR*8-1:0] v;
        for (int i = 0; i < NR; i++) v[8*i +: 8] = m_cfg[i];
        return v;
    endfunction

    function automatic logic [NR*13-1:0] model_conf_addr();
        logic [NR*13-1:0] v;
        for (int i = 0; i < NR; i++) v[13*i +: 13] = m_addr[i];
        return v;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_timeout: ready=%b required 1", ready);
        end
    endtask

    // One full transaction: drive at negedge, check the response cycle and the return to idle.
    task automatic xact(input logic w, input logic [11:0] a, input logic [31:0] d);
        logic [31:0] exp_rd;
        logic        exp_err;
        wait_ready();
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        model_access(w, a, d, exp_rd, exp_err);
        @(negedge clk);
        vectors++;
        if (rvalid !== 1'b1 || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL resp_handshake: rvalid=%b ready=%b required rvalid=1 ready=0", rvalid, ready);
        end
        vectors++;
        if (rdata !== exp_rd || err !== exp_err) begin
            miscompares++;
            $display("FAIL resp_data addr=%h: rdata=%h err=%b required rdata=%h err=%b",
                     a, rdata, err, exp_rd, exp_err);
        end
        vectors++;
        if (conf !== model_conf() || conf_addr !== model_conf_addr()) begin
            miscompares++;
            $display("FAIL conf_outputs addr=%h: conf=%h conf_addr=%h required conf=%h conf_addr=%h",
                     a, conf, conf_addr, model_conf(), model_conf_addr());
        end
        $display("xact we=%0d addr=%h wdata=%h -> rdata=%h err=%0d", w, a, d, rdata, err);
        @(negedge clk);
        vectors++;
        if (rvalid !== 1'b0 || ready !== 1'b1) begin
            miscompares++;
            $display("FAIL resp_one_cycle: rvalid=%b ready=%b required rvalid=0 ready=1", rvalid, ready);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (ready !== 1'b1 || rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_port_state: ready=%b rvalid=%b err=%b rdata=%h required 1 0 0 0",
                     ready, rvalid, err, rdata);
        end
        vectors++;
        if (conf !== '0 || conf_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_conf: conf=%h conf_addr=%h required 0 0", conf, conf_addr);
        end
        xact(1'b0, 12'h3A0, 32'hDEAD_BEEF);
        xact(1'b0, 12'h3B0, 32'h0);
    endtask

    task automatic test_napot();
        xact(1'b1, 12'h3B2, 32'h0000_0CEF);
        xact(1'b1, 12'h3A0, 32'h001F_0000);
        vectors++;
        if (conf_addr[26 +: 13] !== 13'h0CEF || conf[16 +: 8] !== 8'h1F || rdata !== 32'h001F_0000) begin
            miscompares++;
            $display("FAIL napot_entry2: addr=%h cfg=%h rdata=%h required 0cef 1f 001f0000",
                     conf_addr[26 +: 13], conf[16 +: 8], rdata);
        end
    endtask

    task automatic test_warl();
        xact(1'b1, 12'h3A0, 32'h0000_0006);
        vectors++;
        if (conf[7:0] !== 8'h00) begin
            miscompares++;
            $display("FAIL illegal_wr: cfg0=%h required 00", conf[7:0]);
        end
        xact(1'b1, 12'h3A0, 32'h0000_6000);
        vectors++;
        if (conf[15:8] !== 8'h00) begin
            miscompares++;
            $display("FAIL reserved_bits: cfg1=%h required 00", conf[15:8]);
        end
    endtask

    task automatic test_lock();
        xact(1'b1, 12'h3A0, 32'h0000_8900);
        xact(1'b1, 12'h3B1, 32'h0000_1234);
        xact(1'b1, 12'h3B0, 32'h0000_0055);
        vectors++;
        if (conf_addr[12:0] !== 13'h0 || conf_addr[25:13] !== 13'h0) begin
            miscompares++;
            $display("FAIL locked_addr: a0=%h a1=%h required 0 0", conf_addr[12:0], conf_addr[25:13]);
        end
        xact(1'b1, 12'h3A0, 32'h0000_0000);
        vectors++;
        if (conf[15:8] !== 8'h89) begin
            miscompares++;
            $display("FAIL locked_cfg: cfg1=%h required 89", conf[15:8]);
        end
    endtask

    task automatic test_bad_addr();
        xact(1'b1, 12'h3A5, 32'hFFFF_FFFF);
        xact(1'b0, 12'h3B7, 32'h0);
        xact(1'b1, 12'h3A1, 32'h1234_5678);
    endtask

    task automatic test_back_to_back();
        logic [11:0] seq [4];
        logic [31:0] exp_rd;
        logic        exp_err;
        int pulses = 0;
        seq[0] = 12'h3A0; seq[1] = 12'h3B2; seq[2] = 12'h3B7; seq[3] = 12'h3B1;
        wait_ready();
        req = 1'b1; we = 1'b0; addr = seq[0]; wdata = $urandom;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            if (c % 2 == 0) begin
                model_access(1'b0, seq[c/2], wdata, exp_rd, exp_err);
                if (c / 2 + 1 < 4) addr = seq[c/2 + 1];
                else req = 1'b0;
            end
            vectors++;
            if (ready !== (c % 2 == 1) || rvalid !== (c % 2 == 0)) begin
                miscompares++;
                $display("FAIL b2b_handshake c=%0d: ready=%b rvalid=%b required %b %b",
                         c, ready, rvalid, c % 2 == 1, c % 2 == 0);
            end
            if (rvalid === 1'b1) begin
                pulses++;
                vectors++;
                if (rdata !== exp_rd || err !== exp_err) begin
                    miscompares++;
                    $display("FAIL b2b_data c=%0d: rdata=%h err=%b required %h %b",
                             c, rdata, err, exp_rd, exp_err);
                end
                $display("xact b2b read addr=%h -> rdata=%h err=%0d", seq[c/2], rdata, err);
            end
        end
        vectors++;
        if (pulses != 4) begin
            miscompares++;
            $display("FAIL b2b_pulses: got %0d required 4", pulses);
        end
    endtask

    task automatic test_reset_in_resp();
        xact(1'b1, 12'h3A0, 32'h8F00_0000);
        wait_ready();
        req = 1'b1; we = 1'b1; addr = 12'h3B3; wdata = 32'h0000_0AAA;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_rvalid: rvalid=%b required 0", rvalid);
        end
        $display("xact aborted by reset addr=3b3");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        vectors++;
        if (conf !== '0 || conf_addr !== '0 || rdata !== 32'h0 || err !== 1'b0 || ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_state: conf=%h conf_addr=%h rdata=%h err=%b ready=%b required all 0 and ready 1",
                     conf, conf_addr, rdata, err, ready);
        end
        xact(1'b1, 12'h3A0, 32'h0700_0000);
        xact(1'b1, 12'h3B3, 32'h0000_0123);
    endtask

    task automatic test_random();
        logic [11:0] a;
        logic [31:0] d;
        apply_reset();
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 9))
                0, 9:    a = 12'h3A0;
                1:       a = 12'h3A1;
                2:       a = 12'h3A5;
                3:       a = 12'h3B0;
                4:       a = 12'h3B1;
                5:       a = 12'h3B2;
                6:       a = 12'h3B3;
                7:       a = 12'h3B7;
                default: a = 12'($urandom);
            endcase
            d = $urandom;
            if (a == 12'h3A0 && $urandom_range(0, 3) != 0) d = d & 32'h7F7F_7F7F;
            xact(1'($urandom_range(0, 1)), a, d);
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_napot();
        test_warl();
        test_lock();
        test_bad_addr();
        test_back_to_back();
        test_reset_in_resp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
